// File: rtl/dma_ram_pkg.sv
// Shared types and default sizing for the burst DMA RAM block.
package dma_ram_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StWrite
  } state_e;

  localparam int unsigned DefDataW = 16;
  localparam int unsigned DefAddrW = 16;
  localparam int unsigned DefDepth = 1024;
  localparam int unsigned DefLenW  = 8;

endpackage

// File: rtl/dma_burst_ram_if.sv
// Command, write-beat and read-beat signals of the burst DMA RAM.
interface dma_burst_ram_if
  import dma_ram_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned LEN_W  = DefLenW
) ();

  logic              read_signal;
  logic              write_signal;
  logic [ADDR_W-1:0] address;
  logic [LEN_W-1:0]  burst_len;
  logic [DATA_W-1:0] data;
  logic              data_valid;
  logic              write_ready;
  logic [DATA_W-1:0] dataout;
  logic              dataout_valid;
  logic              busy;
  logic              doneRead;
  logic              doneWrite;
  logic              err;

  modport slave (
    input  read_signal, write_signal, address, burst_len, data, data_valid,
    output write_ready, dataout, dataout_valid, busy, doneRead, doneWrite, err
  );

  modport master (
    output read_signal, write_signal, address, burst_len, data, data_valid,
    input  write_ready, dataout, dataout_valid, busy, doneRead, doneWrite, err
  );

endinterface

// File: rtl/ram_array.sv
// Single-port synchronous RAM with registered read data; contents are never reset.
module ram_array #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned AW     = 10
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[addr_i] <= wdata_i;
    end
  end

  // Only the read register is reset; it holds between read beats.
  always_ff @(posedge clk) begin
    if (!RST) begin
      rdata_o <= '0;
    end else if (re_i) begin
      rdata_o <= mem[addr_i];
    end
  end

endmodule

// File: rtl/dma_burst_ram.sv
// Burst DMA front end: accepts read/write burst commands and streams beats to/from ram_array.
module dma_burst_ram
  import dma_ram_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DEPTH  = DefDepth,
  parameter int unsigned LEN_W  = DefLenW
) (
  input logic             clk,
  input logic             RST,
  dma_burst_ram_if.slave  bus
);

  localparam int unsigned       AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DepthW   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  state_e            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [LEN_W-1:0]  remaining_q;
  logic              dataout_valid_q;
  logic              done_read_q;
  logic              done_write_q;
  logic              err_q;

  logic              cmd;
  logic              cmd_bad;
  logic              ram_we;
  logic              ram_re;
  logic [ADDR_W-1:0] ptr_next;

  assign cmd      = bus.read_signal | bus.write_signal;
  assign cmd_bad  = (bus.burst_len == '0) || ({1'b0, bus.address} >= DepthW);
  // Gate RAM strobes with reset so an aborting edge never touches memory.
  assign ram_we   = RST && (state_q == StWrite) && bus.data_valid;
  assign ram_re   = RST && (state_q == StRead);
  assign ptr_next = (ptr_q == LastAddr) ? '0 : ptr_q + ADDR_W'(1);

  always_ff @(posedge clk) begin
    if (!RST) begin
      state_q         <= StIdle;
      ptr_q           <= '0;
      remaining_q     <= '0;
      dataout_valid_q <= 1'b0;
      done_read_q     <= 1'b0;
      done_write_q    <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      dataout_valid_q <= 1'b0;
      done_read_q     <= 1'b0;
      done_write_q    <= 1'b0;
      err_q           <= 1'b0;
      case (state_q)
        StIdle: begin
          if (cmd) begin
            if (cmd_bad) begin
              err_q <= 1'b1;
            end else begin
              ptr_q       <= bus.address;
              remaining_q <= bus.burst_len;
              state_q     <= bus.read_signal ? StRead : StWrite;
            end
          end
        end
        StRead: begin
          dataout_valid_q <= 1'b1;
          ptr_q           <= ptr_next;
          remaining_q     <= remaining_q - LEN_W'(1);
          if (remaining_q == LEN_W'(1)) begin
            done_read_q <= 1'b1;
            state_q     <= StIdle;
          end
        end
        StWrite: begin
          if (bus.data_valid) begin
            ptr_q       <= ptr_next;
            remaining_q <= remaining_q - LEN_W'(1);
            if (remaining_q == LEN_W'(1)) begin
              done_write_q <= 1'b1;
              state_q      <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy          = (state_q != StIdle);
  assign bus.write_ready   = (state_q == StWrite);
  assign bus.dataout_valid = dataout_valid_q;
  assign bus.doneRead      = done_read_q;
  assign bus.doneWrite     = done_write_q;
  assign bus.err           = err_q;

  ram_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk     (clk),
    .RST     (RST),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .addr_i  (ptr_q[AW-1:0]),
    .wdata_i (bus.data),
    .rdata_o (bus.dataout)
  );

endmodule

// File: tb/tb_dma_burst_ram.sv
// Randomized bench for dma_burst_ram against an array-based memory model.
module tb_dma_burst_ram;

  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 16;
  localparam int unsigned DEPTH = 1024;
  localparam int unsigned LW    = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dma_burst_ram_if #(.DATA_W(DW), .ADDR_W(AW), .LEN_W(LW)) bus ();

  dma_burst_ram #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .DEPTH  (DEPTH),
    .LEN_W  (LW)
  ) dut (
    .clk (clk),
    .RST (rst),
    .bus (bus)
  );

  logic [DW-1:0] model_mem [DEPTH];
  bit            known     [DEPTH];
  logic [DW-1:0] wbuf      [256];
  int            n_checks = 0;
  int            n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_idle();
    bus.read_signal  = 1'b0;
    bus.write_signal = 1'b0;
    bus.address      = '0;
    bus.burst_len    = '0;
    bus.data         = '0;
    bus.data_valid   = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_busy"}, 32'(bus.busy), 0);
    check_eq({tag, "_wrdy"}, 32'(bus.write_ready), 0);
    check_eq({tag, "_dvld"}, 32'(bus.dataout_valid), 0);
    check_eq({tag, "_drd"},  32'(bus.doneRead), 0);
    check_eq({tag, "_dwr"},  32'(bus.doneWrite), 0);
    check_eq({tag, "_err"},  32'(bus.err), 0);
    check_eq({tag, "_dout"}, 32'(bus.dataout), 0);
  endtask

  // gap_mode: 0 none, 1 two idle cycles before beat 1, 2 random idles.
  task automatic do_write(input int addr, input int len, input int gap_mode, input int abort_after);
    bus.write_signal = 1'b1;
    bus.address      = AW'(addr);
    bus.burst_len    = LW'(len);
    @(negedge clk);
    bus.write_signal = 1'b0;
    check_eq("wr_busy", 32'(bus.busy), 1);
    check_eq("wr_rdy", 32'(bus.write_ready), 1);
    for (int i = 0; i < len; i++) begin
      int ngap;
      int a;
      ngap = (gap_mode == 1 && i == 1) ? 2 : ((gap_mode == 2) ? int'($urandom_range(0, 2)) : 0);
      for (int g = 0; g < ngap; g++) begin
        @(negedge clk);
        check_eq("wr_rdy_gap", 32'(bus.write_ready), 1);
        check_eq("wr_done_gap", 32'(bus.doneWrite), 0);
      end
      bus.data       = wbuf[i];
      bus.data_valid = 1'b1;
      @(negedge clk);
      bus.data_valid = 1'b0;
      a = (addr + i) % DEPTH;
      model_mem[a] = wbuf[i];
      known[a]     = 1'b1;
      if (abort_after == i + 1) begin
        rst = 1'b0;
        @(negedge clk);
        check_zero_outputs("abort");
        rst = 1'b1;
        return;
      end
      check_eq("wr_done", 32'(bus.doneWrite), 32'(i == len - 1));
      check_eq("wr_rdy_beat", 32'(bus.write_ready), 32'(i != len - 1));
      check_eq("wr_busy_beat", 32'(bus.busy), 32'(i != len - 1));
    end
    @(negedge clk);
    check_eq("wr_done_pulse", 32'(bus.doneWrite), 0);
  endtask

  // poke drives a write command every beat while the read is in flight.
  task automatic do_read(input int addr, input int len, input bit both, input bit poke);
    int last_a;
    bus.read_signal  = 1'b1;
    bus.write_signal = both;
    bus.address      = AW'(addr);
    bus.burst_len    = LW'(len);
    @(negedge clk);
    bus.read_signal  = 1'b0;
    bus.write_signal = 1'b0;
    check_eq("rd_busy0", 32'(bus.busy), 1);
    check_eq("rd_vld0", 32'(bus.dataout_valid), 0);
    last_a = addr;
    for (int i = 0; i < len; i++) begin
      int a;
      a = (addr + i) % DEPTH;
      if (poke) begin
        bus.write_signal = 1'b1;
        bus.address      = AW'(7);
        bus.burst_len    = LW'(2);
        bus.data         = 16'hDEAD;
        bus.data_valid   = 1'b1;
      end
      @(negedge clk);
      bus.write_signal = 1'b0;
      bus.data_valid   = 1'b0;
      check_eq("rd_vld", 32'(bus.dataout_valid), 1);
      if (known[a]) check_eq("rd_data", 32'(bus.dataout), 32'(model_mem[a]));
      check_eq("rd_done", 32'(bus.doneRead), 32'(i == len - 1));
      check_eq("rd_busy", 32'(bus.busy), 32'(i != len - 1));
      last_a = a;
    end
    @(negedge clk);
    check_eq("rd_vld_end", 32'(bus.dataout_valid), 0);
    check_eq("rd_done_pulse", 32'(bus.doneRead), 0);
    check_eq("rd_idle", 32'(bus.busy), 0);
    if (known[last_a]) check_eq("rd_hold", 32'(bus.dataout), 32'(model_mem[last_a]));
  endtask

  task automatic do_reject(input int addr, input int len, input bit is_read);
    bus.read_signal  = is_read;
    bus.write_signal = !is_read;
    bus.address      = AW'(addr);
    bus.burst_len    = LW'(len);
    @(negedge clk);
    drive_idle();
    check_eq("rej_err", 32'(bus.err), 1);
    check_eq("rej_busy", 32'(bus.busy), 0);
    @(negedge clk);
    check_eq("rej_err_pulse", 32'(bus.err), 0);
    check_eq("rej_done", 32'(bus.doneRead | bus.doneWrite), 0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    drive_idle();
    for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
    // Commands asserted during reset must be ignored.
    rst              = 1'b0;
    bus.read_signal  = 1'b1;
    bus.write_signal = 1'b1;
    bus.address      = AW'(5);
    bus.burst_len    = LW'(3);
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    drive_idle();
    rst = 1'b1;
    @(negedge clk);
    check_eq("post_reset_busy", 32'(bus.busy), 0);

    // Populate every word so later reads are fully predictable.
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 255; i++) wbuf[i] = DW'($urandom);
      do_write(b * 255, 255, 0, 0);
    end
    for (int i = 0; i < 4; i++) wbuf[i] = DW'($urandom);
    do_write(1020, 4, 0, 0);

    wbuf[0] = 16'h00A1; wbuf[1] = 16'h00A2; wbuf[2] = 16'h00A3;
    do_write(5, 3, 1, 0);
    do_read(5, 3, 1'b0, 1'b0);

    wbuf[0] = 16'h0011; wbuf[1] = 16'h0022;
    do_write(DEPTH - 1, 2, 0, 0);
    do_read(0, 1, 1'b0, 1'b0);

    do_read(5, 1, 1'b1, 1'b0);
    do_reject(DEPTH, 1, 1'b1);
    do_reject(5, 0, 1'b0);

    wbuf[0] = 16'h0055; wbuf[1] = 16'h0066; wbuf[2] = 16'h0077; wbuf[3] = 16'h0088;
    do_write(20, 4, 0, 2);
    do_read(20, 4, 1'b0, 1'b0);

    do_read(5, 3, 1'b0, 1'b1);
    do_read(5, 3, 1'b0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      int r;
      int addr;
      int len;
      r    = int'($urandom_range(0, 9));
      addr = ($urandom_range(0, 1) == 0) ? int'($urandom_range(DEPTH - 8, DEPTH - 1))
                                         : int'($urandom_range(0, DEPTH - 1));
      len  = int'($urandom_range(1, 16));
      if (r == 0) begin
        if ($urandom_range(0, 1) == 0) do_reject(int'($urandom_range(DEPTH, 65535)), len, 1'b1);
        else do_reject(addr, 0, 1'b0);
      end else if (r < 5) begin
        for (int i = 0; i < len; i++) wbuf[i] = DW'($urandom);
        if (r == 1 && len > 1) do_write(addr, len, 2, int'($urandom_range(1, len - 1)));
        else do_write(addr, len, 2, 0);
      end else begin
        do_read(addr, len, r == 9, r == 8);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dma_burst_ram.md
DMA_BURST_RAM -- requirements
Module: dma_burst_ram

Interface
REQ-001 Parameter DATA_W, default 16, data word width.
REQ-002 Parameter ADDR_W, default 16, address width.
REQ-003 Parameter DEPTH, default 1024, number of words; DEPTH <= 2**ADDR_W.
REQ-004 Parameter LEN_W, default 8, burst-length field width.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 RST  in  1  reset, synchronous, active-low.
REQ-007 read_signal  in  1  read-burst command request.
REQ-008 write_signal  in  1  write-burst command request.
REQ-009 address  in  ADDR_W  burst start address, sampled at command acceptance.
REQ-010 burst_len  in  LEN_W  beat count N, sampled at acceptance; 1..2**LEN_W-1.
REQ-011 data  in  DATA_W  write beat data.
REQ-012 data_valid  in  1  write beat present on data.
REQ-013 write_ready  out  1  high while in WRITE; beat accepted when write_ready and data_valid.
REQ-014 dataout  out  DATA_W  read beat data, registered.
REQ-015 dataout_valid  out  1  dataout carries a new beat this cycle.
REQ-016 busy  out  1  burst in progress; commands ignored.
REQ-017 doneRead  out  1  one-cycle pulse with last read beat.
REQ-018 doneWrite  out  1  one-cycle pulse after last write beat stored.
REQ-019 err  out  1  one-cycle pulse on rejected command.

Function
REQ-020 States IDLE, READ, WRITE; busy = (state != IDLE).
REQ-021 In IDLE, command accepted at edge where read_signal or write_signal high; both high -> read wins.
REQ-022 Rejection: burst_len == 0 or address >= DEPTH -> err pulse next cycle, state stays IDLE, no memory access, no done pulse.
REQ-023 Acceptance at edge k loads ptr = address, remaining = burst_len, enters READ or WRITE.
REQ-024 READ: edges k+1..k+N each register dataout = mem[ptr], dataout_valid = 1, ptr advances; no stalls.
REQ-025 READ last beat (edge k+N): doneRead = 1, busy = 0, state -> IDLE in same cycle as final dataout_valid.
REQ-026 WRITE: at each edge with data_valid high, mem[ptr] = data, ptr advances, remaining decrements; data_valid low stalls indefinitely.
REQ-027 WRITE last beat: doneWrite pulse next cycle, write_ready drops, state -> IDLE.
REQ-028 ptr wraps modulo DEPTH (DEPTH-1 -> 0) mid-burst; no error.
REQ-029 Earliest next command acceptance: edge after busy falls; back-to-back bursts lose zero cycles beyond that.
REQ-030 dataout holds its last value when dataout_valid low.
REQ-031 Commands asserted while busy are dropped, not queued.
REQ-032 Read-after-write to same address in consecutive bursts returns new data.

Reset
REQ-033 RST low at an edge: state IDLE, busy, write_ready, dataout_valid, doneRead, doneWrite, err = 0, dataout = 0, ptr/remaining = 0.
REQ-034 Reset mid-burst aborts without done pulse; already-written words retained; memory array never cleared by reset.
REQ-035 Commands during RST low ignored.

Structure
REQ-036 Package dma_ram_pkg holds state enum type and default parameter constants.
REQ-037 One sub-module ram_array: single-port synchronous RAM, DEPTH x DATA_W, registered read, write-enable; control FSM in dma_burst_ram.

Verification
REQ-038 Reset then write burst address=5, len=3, data 0xA1,0xA2,0xA3 with data_valid gap after beat 1 -> write_ready stays high through gap, doneWrite one pulse, busy low after.
REQ-039 Read burst address=5, len=3 -> dataout 0xA1,0xA2,0xA3 on 3 consecutive cycles, doneRead with 0xA3, busy 3 cycles.
REQ-040 Write address=DEPTH-1 (1023), len=2 data 0x11,0x22, then read address=0 len=1 -> 0x22 (wrap).
REQ-041 read_signal and write_signal both high, address=5 len=1 -> read of 0xA1, memory unchanged; then address=1024 or len=0 -> err pulse, busy stays 0.
REQ-042 Write address=20 len=4, RST low after 2 beats (0x55,0x66) -> no doneWrite, outputs zero; read 20 len=2 -> 0x55,0x66.
REQ-043 Command pulse during busy read -> ignored; no extra beats or done pulses.
